coz: RTL and testbench
======================

COZ -- requirements
Module: coz

Interface
- REQ-001 Parameter BOS_BUYRUK, default 32'h0000_0013, is the NOP encoding treated as a bubble.
- REQ-002 Clocking: one clock; reset is synchronous and active-high.
- REQ-003 clk_i  input  1  clock.
- REQ-004 rst_i  input  1  synchronous active-high reset.
- REQ-005 ps_i  input  32  PC of the instruction delivered by getir.
- REQ-006 buyruk_i  input  32  instruction from getir; BOS_BUYRUK means bubble.
- REQ-007 ongoru_gecerli_i  input  1  getir predicted this branch taken.
- REQ-008 durdur_i  input  1  downstream stall.
- REQ-009 bosalt_i  input  1  flush (dallanma_hata | jal_gecerli | mret_gecerli).
- REQ-010 rs1_adres_o, rs2_adres_o  output  5  register-file read addresses, combinational from buyruk_i[19:15] and [24:20].
- REQ-011 rs1_veri_i, rs2_veri_i  input  32  register-file read data, same cycle.
- REQ-012 durdur_o  output  1  stall request to getir.
- REQ-013 Registered outputs: gecerli_o 1, ps_o 32, islem_o 6 (operation code), rd_o 5, rd_yaz_o 1, imm_o 32, rs1_deger_o 32, rs2_deger_o 32, rs1_o 5, rs2_o 5, ongoru_gecerli_o 1, gecersiz_buyruk_o 1.

Function
- REQ-014 Latency: exactly one cycle from buyruk_i to the registered outputs.
- REQ-015 Register update priority: rst_i > bosalt_i > durdur_i > load-use bubble > normal load.
- REQ-016 When bosalt_i=1, the block loads a bubble: gecerli_o=0, rd_yaz_o=0, ongoru_gecerli_o=0, gecersiz_buyruk_o=0; other fields don't-care. This applies even when durdur_i=1.
- REQ-017 When durdur_i=1 and bosalt_i=0, all output registers hold their values.
- REQ-018 Load-use hazard (tehlike) holds when gecerli_o=1, islem_o is a load, rd_o!=0, and either (rd_o==rs1 and the current instruction uses rs1) or (rd_o==rs2 and the current instruction uses rs2).
- REQ-019 rs1 is used by every opcode except LUI, AUIPC and JAL; rs2 is used by BRANCH, STORE and OP only.
- REQ-020 On a hazard with no stall or flush, the block loads a bubble and asserts durdur_o; the next cycle re-decodes the same buyruk_i, which getir holds.
- REQ-021 durdur_o = durdur_i | tehlike, combinational; bosalt_i=1 forces tehlike=0.
- REQ-022 Normal load: gecerli_o = (buyruk_i != BOS_BUYRUK); the ps, rd, rs, register data and prediction fields are captured.
- REQ-023 imm_o is sign-extended per RV32I I/S/B/U/J format; B and J immediates have bit 0 = 0; R-type imm_o = 0.
- REQ-024 rd_yaz_o = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, and only when rd != 0; otherwise 0.
- REQ-025 An unknown opcode, funct3 or funct7 sets gecersiz_buyruk_o=1 with gecerli_o=1 and rd_yaz_o=0.
- REQ-026 x0 reads: when the source address is 0, rs1_deger_o/rs2_deger_o are forced to 0 regardless of rs*_veri_i.

Reset
- REQ-027 While rst_i=1 at a clock edge: gecerli_o=0, rd_yaz_o=0, ongoru_gecerli_o=0, gecersiz_buyruk_o=0, ps_o=0, islem_o=NOP code, and all other registered outputs = 0.
- REQ-028 durdur_o = durdur_i during reset.
- REQ-029 Reset applied mid-stall or mid-hazard clears all state with no residue on the next cycle.

Structure
- REQ-030 A shared package holds the RV32I opcode constants, the islem_o encodings (including the NOP and load class) and BOS_BUYRUK.
- REQ-031 The immediate generator is one sub-module, imm_uretici, and is purely combinational.
- REQ-032 Hazard detection and the field decode are contained in coz.

Verification
- REQ-033 buyruk_i=32'h00500093 (addi x1,x0,5), ps_i=32'h100 -> next cycle gecerli_o=1, rd_o=1, rd_yaz_o=1, imm_o=5, ps_o=32'h100.
- REQ-034 lw x2,0(x1), then add x3,x2,x2 -> durdur_o=1 for one cycle, one bubble (gecerli_o=0), then add issues with gecerli_o=1.
- REQ-035 lw x0,0(x1), then add x3,x0,x0 -> no durdur_o and no bubble.
- REQ-036 durdur_i=1 and bosalt_i=1 in the same cycle -> next gecerli_o=0 and durdur_o=1.
- REQ-037 buyruk_i=32'hFE000EE3 (beq with offset -4) -> imm_o=32'hFFFFFFFC; ongoru_gecerli_i=1 propagates to ongoru_gecerli_o.
- REQ-038 buyruk_i=32'hFFFFFFFF -> gecersiz_buyruk_o=1, rd_yaz_o=0; rst_i pulse -> all flags 0.

Source files
------------

// File: rtl/coz_pkg.sv
// Shared constants for the decode stage: RV32I major opcodes, the islem_o
// operation encodings and the bubble instruction word.
package coz_pkg;

  // Default bubble word: addi x0, x0, 0
  localparam logic [31:0] BOS_BUYRUK_VARSAYILAN = 32'h0000_0013;

  // RV32I major opcodes handled by this decoder
  localparam logic [6:0] OPK_LUI    = 7'b0110111;
  localparam logic [6:0] OPK_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPK_JAL    = 7'b1101111;
  localparam logic [6:0] OPK_JALR   = 7'b1100111;
  localparam logic [6:0] OPK_BRANCH = 7'b1100011;
  localparam logic [6:0] OPK_LOAD   = 7'b0000011;
  localparam logic [6:0] OPK_STORE  = 7'b0100011;
  localparam logic [6:0] OPK_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPK_OP     = 7'b0110011;

  // Operation codes carried on islem_o. Loads are kept contiguous so the
  // load class can be tested with a range compare.
  typedef enum logic [5:0] {
    ISLEM_NOP = 6'd0,
    ISLEM_LUI, ISLEM_AUIPC, ISLEM_JAL, ISLEM_JALR,
    ISLEM_BEQ, ISLEM_BNE, ISLEM_BLT, ISLEM_BGE, ISLEM_BLTU, ISLEM_BGEU,
    ISLEM_LB, ISLEM_LH, ISLEM_LW, ISLEM_LBU, ISLEM_LHU,
    ISLEM_SB, ISLEM_SH, ISLEM_SW,
    ISLEM_ADDI, ISLEM_SLTI, ISLEM_SLTIU, ISLEM_XORI, ISLEM_ORI, ISLEM_ANDI,
    ISLEM_SLLI, ISLEM_SRLI, ISLEM_SRAI,
    ISLEM_ADD, ISLEM_SUB, ISLEM_SLL, ISLEM_SLT, ISLEM_SLTU,
    ISLEM_XOR, ISLEM_SRL, ISLEM_SRA, ISLEM_OR, ISLEM_AND
  } islem_e;

  // True when the operation code belongs to the load class
  function automatic logic yukleme_mi(input logic [5:0] islem);
    return (islem >= ISLEM_LB) && (islem <= ISLEM_LHU);
  endfunction

  // rs1 is read by every opcode except LUI, AUIPC and JAL
  function automatic logic rs1_kullanir(input logic [6:0] opkod);
    return !((opkod == OPK_LUI) || (opkod == OPK_AUIPC) || (opkod == OPK_JAL));
  endfunction

  // rs2 is read only by BRANCH, STORE and OP
  function automatic logic rs2_kullanir(input logic [6:0] opkod);
    return (opkod == OPK_BRANCH) || (opkod == OPK_STORE) || (opkod == OPK_OP);
  endfunction

endpackage

// File: rtl/coz_imm_uretici.sv
// Immediate generator: sign-extended RV32I I/S/B/U/J immediates, zero for
// R-type and unrecognised opcodes. Purely combinational.
module imm_uretici
  import coz_pkg::*;
(
  input  logic [31:0] buyruk_i,
  output logic [31:0] imm_o
);

  // Select the immediate layout from the major opcode
  always_comb begin
    imm_o = '0;
    case (buyruk_i[6:0])
      OPK_JALR, OPK_LOAD, OPK_OP_IMM:
        imm_o = {{20{buyruk_i[31]}}, buyruk_i[31:20]};
      OPK_STORE:
        imm_o = {{20{buyruk_i[31]}}, buyruk_i[31:25], buyruk_i[11:7]};
      OPK_BRANCH:
        imm_o = {{19{buyruk_i[31]}}, buyruk_i[31], buyruk_i[7],
                 buyruk_i[30:25], buyruk_i[11:8], 1'b0};
      OPK_LUI, OPK_AUIPC:
        imm_o = {buyruk_i[31:12], 12'b0};
      OPK_JAL:
        imm_o = {{11{buyruk_i[31]}}, buyruk_i[31], buyruk_i[19:12],
                 buyruk_i[20], buyruk_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/coz.sv
// Decode stage: splits the fetched word into fields, reads the register
// file, detects load-use hazards and registers the decoded bundle.
//
// Flow control: getir presents ps_i/buyruk_i every cycle. While durdur_o is
// high getir must hold the same ps_i/buyruk_i; the word is consumed on the
// first clock edge where durdur_o is low. bosalt_i discards whatever is in
// flight and loads a bubble regardless of durdur_i.
module coz
  import coz_pkg::*;
#(
  parameter logic [31:0] BOS_BUYRUK = BOS_BUYRUK_VARSAYILAN
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ps_i,
  input  logic [31:0] buyruk_i,
  input  logic        ongoru_gecerli_i,
  input  logic        durdur_i,
  input  logic        bosalt_i,
  output logic [4:0]  rs1_adres_o,
  output logic [4:0]  rs2_adres_o,
  input  logic [31:0] rs1_veri_i,
  input  logic [31:0] rs2_veri_i,
  output logic        durdur_o,
  output logic        gecerli_o,
  output logic [31:0] ps_o,
  output logic [5:0]  islem_o,
  output logic [4:0]  rd_o,
  output logic        rd_yaz_o,
  output logic [31:0] imm_o,
  output logic [31:0] rs1_deger_o,
  output logic [31:0] rs2_deger_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        ongoru_gecerli_o,
  output logic        gecersiz_buyruk_o
);

  logic [6:0]  opkod;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_alan;
  logic [31:0] imm_d;
  islem_e      cozulen_islem;
  logic        yazar;
  logic        gecersiz;
  logic        tehlike;

  assign opkod       = buyruk_i[6:0];
  assign f3          = buyruk_i[14:12];
  assign f7          = buyruk_i[31:25];
  assign rd_alan     = buyruk_i[11:7];
  assign rs1_adres_o = buyruk_i[19:15];
  assign rs2_adres_o = buyruk_i[24:20];

  imm_uretici u_imm (
    .buyruk_i (buyruk_i),
    .imm_o    (imm_d)
  );

  // Field decode: operation code, destination-write class and illegal flag
  always_comb begin
    cozulen_islem = ISLEM_NOP;
    yazar         = 1'b0;
    gecersiz      = 1'b0;
    case (opkod)
      OPK_LUI:   begin cozulen_islem = ISLEM_LUI;   yazar = 1'b1; end
      OPK_AUIPC: begin cozulen_islem = ISLEM_AUIPC; yazar = 1'b1; end
      OPK_JAL:   begin cozulen_islem = ISLEM_JAL;   yazar = 1'b1; end
      OPK_JALR: begin
        yazar = 1'b1;
        if (f3 == 3'b000) cozulen_islem = ISLEM_JALR;
        else              gecersiz = 1'b1;
      end
      OPK_BRANCH: begin
        case (f3)
          3'b000:  cozulen_islem = ISLEM_BEQ;
          3'b001:  cozulen_islem = ISLEM_BNE;
          3'b100:  cozulen_islem = ISLEM_BLT;
          3'b101:  cozulen_islem = ISLEM_BGE;
          3'b110:  cozulen_islem = ISLEM_BLTU;
          3'b111:  cozulen_islem = ISLEM_BGEU;
          default: gecersiz = 1'b1;
        endcase
      end
      OPK_LOAD: begin
        yazar = 1'b1;
        case (f3)
          3'b000:  cozulen_islem = ISLEM_LB;
          3'b001:  cozulen_islem = ISLEM_LH;
          3'b010:  cozulen_islem = ISLEM_LW;
          3'b100:  cozulen_islem = ISLEM_LBU;
          3'b101:  cozulen_islem = ISLEM_LHU;
          default: gecersiz = 1'b1;
        endcase
      end
      OPK_STORE: begin
        case (f3)
          3'b000:  cozulen_islem = ISLEM_SB;
          3'b001:  cozulen_islem = ISLEM_SH;
          3'b010:  cozulen_islem = ISLEM_SW;
          default: gecersiz = 1'b1;
        endcase
      end
      OPK_OP_IMM: begin
        yazar = 1'b1;
        case (f3)
          3'b000: cozulen_islem = ISLEM_ADDI;
          3'b010: cozulen_islem = ISLEM_SLTI;
          3'b011: cozulen_islem = ISLEM_SLTIU;
          3'b100: cozulen_islem = ISLEM_XORI;
          3'b110: cozulen_islem = ISLEM_ORI;
          3'b111: cozulen_islem = ISLEM_ANDI;
          3'b001: begin
            if (f7 == 7'b0000000) cozulen_islem = ISLEM_SLLI;
            else                  gecersiz = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      cozulen_islem = ISLEM_SRLI;
            else if (f7 == 7'b0100000) cozulen_islem = ISLEM_SRAI;
            else                       gecersiz = 1'b1;
          end
        endcase
      end
      OPK_OP: begin
        yazar = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: cozulen_islem = ISLEM_ADD;
          {7'b0100000, 3'b000}: cozulen_islem = ISLEM_SUB;
          {7'b0000000, 3'b001}: cozulen_islem = ISLEM_SLL;
          {7'b0000000, 3'b010}: cozulen_islem = ISLEM_SLT;
          {7'b0000000, 3'b011}: cozulen_islem = ISLEM_SLTU;
          {7'b0000000, 3'b100}: cozulen_islem = ISLEM_XOR;
          {7'b0000000, 3'b101}: cozulen_islem = ISLEM_SRL;
          {7'b0100000, 3'b101}: cozulen_islem = ISLEM_SRA;
          {7'b0000000, 3'b110}: cozulen_islem = ISLEM_OR;
          {7'b0000000, 3'b111}: cozulen_islem = ISLEM_AND;
          default:              gecersiz = 1'b1;
        endcase
      end
      default: gecersiz = 1'b1;
    endcase
    // An illegal word never carries an operation downstream
    if (gecersiz) cozulen_islem = ISLEM_NOP;
  end

  // Load-use hazard against the load currently sitting in the output register
  always_comb begin
    tehlike = 1'b0;
    if (!rst_i && !bosalt_i && gecerli_o && yukleme_mi(islem_o) && (rd_o != 5'd0)) begin
      tehlike = ((rd_o == rs1_adres_o) && rs1_kullanir(opkod)) ||
                ((rd_o == rs2_adres_o) && rs2_kullanir(opkod));
    end
  end

  assign durdur_o = durdur_i | tehlike;

  // Output register: reset > flush > stall hold > hazard bubble > load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gecerli_o         <= 1'b0;
      ps_o              <= '0;
      islem_o           <= ISLEM_NOP;
      rd_o              <= '0;
      rd_yaz_o          <= 1'b0;
      imm_o             <= '0;
      rs1_deger_o       <= '0;
      rs2_deger_o       <= '0;
      rs1_o             <= '0;
      rs2_o             <= '0;
      ongoru_gecerli_o  <= 1'b0;
      gecersiz_buyruk_o <= 1'b0;
    end else if (bosalt_i || (!durdur_i && tehlike)) begin
      gecerli_o         <= 1'b0;
      islem_o           <= ISLEM_NOP;
      rd_yaz_o          <= 1'b0;
      ongoru_gecerli_o  <= 1'b0;
      gecersiz_buyruk_o <= 1'b0;
    end else if (!durdur_i) begin
      gecerli_o         <= (buyruk_i != BOS_BUYRUK);
      ps_o              <= ps_i;
      islem_o           <= cozulen_islem;
      rd_o              <= rd_alan;
      rd_yaz_o          <= yazar && !gecersiz && (rd_alan != 5'd0);
      imm_o             <= imm_d;
      rs1_deger_o       <= (rs1_adres_o == 5'd0) ? 32'd0 : rs1_veri_i;
      rs2_deger_o       <= (rs2_adres_o == 5'd0) ? 32'd0 : rs2_veri_i;
      rs1_o             <= rs1_adres_o;
      rs2_o             <= rs2_adres_o;
      ongoru_gecerli_o  <= ongoru_gecerli_i;
      gecersiz_buyruk_o <= gecersiz;
    end
  end

endmodule

// File: tb/tb_coz.sv
// Testbench for coz: directed scenarios followed by randomized traffic,
// checked against an instruction-level reference model through a scoreboard.
module tb_coz;
  import coz_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] ps_i = '0;
  logic [31:0] buyruk_i = 32'h13;
  logic        ongoru_gecerli_i = 1'b0;
  logic        durdur_i = 1'b0;
  logic        bosalt_i = 1'b0;
  logic [4:0]  rs1_adres_o, rs2_adres_o;
  logic [31:0] rs1_veri_i = '0, rs2_veri_i = '0;
  logic        durdur_o, gecerli_o, rd_yaz_o, ongoru_gecerli_o, gecersiz_buyruk_o;
  logic [31:0] ps_o, imm_o, rs1_deger_o, rs2_deger_o;
  logic [5:0]  islem_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;

  always #5 clk_i = ~clk_i;

  coz #(.BOS_BUYRUK(32'h0000_0013)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ps_i(ps_i), .buyruk_i(buyruk_i),
    .ongoru_gecerli_i(ongoru_gecerli_i), .durdur_i(durdur_i), .bosalt_i(bosalt_i),
    .rs1_adres_o(rs1_adres_o), .rs2_adres_o(rs2_adres_o),
    .rs1_veri_i(rs1_veri_i), .rs2_veri_i(rs2_veri_i), .durdur_o(durdur_o),
    .gecerli_o(gecerli_o), .ps_o(ps_o), .islem_o(islem_o), .rd_o(rd_o),
    .rd_yaz_o(rd_yaz_o), .imm_o(imm_o), .rs1_deger_o(rs1_deger_o),
    .rs2_deger_o(rs2_deger_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .ongoru_gecerli_o(ongoru_gecerli_o), .gecersiz_buyruk_o(gecersiz_buyruk_o)
  );

  // ---------------- instruction descriptor and encoder ----------------
  typedef struct {
    logic [31:0] kelime;
    logic [5:0]  islem;
    logic [31:0] imm;
    logic        yazar, gecersiz, yukleme, kul1, kul2;
  } tanim_t;

  // formats: 0=R 1=I 2=S 3=B 4=U 5=J 6=shift-immediate
  function automatic tanim_t kodla(input islem_e op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input int deger);
    tanim_t t;
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; int fmt;
    logic [31:0] im;
    im = deger; f7 = 7'b0; f3 = 3'b0; opc = OPK_OP; fmt = 0;
    case (op)
      ISLEM_LUI:   begin opc = OPK_LUI;   fmt = 4; end
      ISLEM_AUIPC: begin opc = OPK_AUIPC; fmt = 4; end
      ISLEM_JAL:   begin opc = OPK_JAL;   fmt = 5; end
      ISLEM_JALR:  begin opc = OPK_JALR;  fmt = 1; end
      ISLEM_BEQ:   begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd0; end
      ISLEM_BNE:   begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd1; end
      ISLEM_BLT:   begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd4; end
      ISLEM_BGE:   begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd5; end
      ISLEM_BLTU:  begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd6; end
      ISLEM_BGEU:  begin opc = OPK_BRANCH; fmt = 3; f3 = 3'd7; end
      ISLEM_LB:    begin opc = OPK_LOAD; fmt = 1; f3 = 3'd0; end
      ISLEM_LH:    begin opc = OPK_LOAD; fmt = 1; f3 = 3'd1; end
      ISLEM_LW:    begin opc = OPK_LOAD; fmt = 1; f3 = 3'd2; end
      ISLEM_LBU:   begin opc = OPK_LOAD; fmt = 1; f3 = 3'd4; end
      ISLEM_LHU:   begin opc = OPK_LOAD; fmt = 1; f3 = 3'd5; end
      ISLEM_SB:    begin opc = OPK_STORE; fmt = 2; f3 = 3'd0; end
      ISLEM_SH:    begin opc = OPK_STORE; fmt = 2; f3 = 3'd1; end
      ISLEM_SW:    begin opc = OPK_STORE; fmt = 2; f3 = 3'd2; end
      ISLEM_ADDI:  begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd0; end
      ISLEM_SLTI:  begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd2; end
      ISLEM_SLTIU: begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd3; end
      ISLEM_XORI:  begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd4; end
      ISLEM_ORI:   begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd6; end
      ISLEM_ANDI:  begin opc = OPK_OP_IMM; fmt = 1; f3 = 3'd7; end
      ISLEM_SLLI:  begin opc = OPK_OP_IMM; fmt = 6; f3 = 3'd1; end
      ISLEM_SRLI:  begin opc = OPK_OP_IMM; fmt = 6; f3 = 3'd5; end
      ISLEM_SRAI:  begin opc = OPK_OP_IMM; fmt = 6; f3 = 3'd5; f7 = 7'h20; end
      ISLEM_ADD:   begin f3 = 3'd0; end
      ISLEM_SUB:   begin f3 = 3'd0; f7 = 7'h20; end
      ISLEM_SLL:   begin f3 = 3'd1; end
      ISLEM_SLT:   begin f3 = 3'd2; end
      ISLEM_SLTU:  begin f3 = 3'd3; end
      ISLEM_XOR:   begin f3 = 3'd4; end
      ISLEM_SRL:   begin f3 = 3'd5; end
      ISLEM_SRA:   begin f3 = 3'd5; f7 = 7'h20; end
      ISLEM_OR:    begin f3 = 3'd6; end
      default:     begin f3 = 3'd7; end
    endcase
    case (fmt)
      0: begin t.kelime = {f7, rs2, rs1, f3, rd, opc}; t.imm = 32'd0; end
      1: begin t.kelime = {im[11:0], rs1, f3, rd, opc}; t.imm = im; end
      2: begin t.kelime = {im[11:5], rs2, rs1, f3, im[4:0], opc}; t.imm = im; end
      3: begin t.kelime = {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], opc}; t.imm = im; end
      4: begin t.kelime = {im[31:12], rd, opc}; t.imm = im; end
      5: begin t.kelime = {im[20], im[10:1], im[11], im[19:12], rd, opc}; t.imm = im; end
      default: begin
        t.kelime = {f7, im[4:0], rs1, f3, rd, opc};
        t.imm = im + ((op == ISLEM_SRAI) ? 32'd1024 : 32'd0);
      end
    endcase
    t.islem    = op;
    t.yazar    = (fmt != 2) && (fmt != 3);
    t.kul1     = (fmt != 4) && (fmt != 5);
    t.kul2     = (fmt == 0) || (fmt == 2) || (fmt == 3);
    t.gecersiz = 1'b0;
    t.yukleme  = (op == ISLEM_LB) || (op == ISLEM_LH) || (op == ISLEM_LW) ||
                 (op == ISLEM_LBU) || (op == ISLEM_LHU);
    return t;
  endfunction

  function automatic tanim_t ham(input logic [31:0] w);
    tanim_t t;
    t.kelime = w; t.islem = ISLEM_NOP; t.imm = 32'd0; t.yazar = 1'b0;
    t.gecersiz = 1'b1; t.yukleme = 1'b0; t.kul1 = 1'b1; t.kul2 = 1'b0;
    return t;
  endfunction

  function automatic tanim_t rastgele_gecerli();
    islem_e op; int d; int r;
    op = islem_e'($urandom_range(1, 37));
    r = $urandom_range(0, 4);
    case (op)
      ISLEM_LUI, ISLEM_AUIPC: d = int'($urandom_range(0, 1048575)) << 12;
      ISLEM_JAL: d = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      ISLEM_BEQ, ISLEM_BNE, ISLEM_BLT, ISLEM_BGE, ISLEM_BLTU, ISLEM_BGEU:
        d = (int'($urandom_range(0, 4095)) - 2048) * 2;
      ISLEM_SLLI, ISLEM_SRLI, ISLEM_SRAI: d = int'($urandom_range(0, 31));
      default: d = (r == 0) ? -2048 : ((r == 1) ? 2047 : int'($urandom_range(0, 4095)) - 2048);
    endcase
    return kodla(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), d);
  endfunction

  function automatic tanim_t rastgele_gecersiz();
    tanim_t t;
    case ($urandom_range(0, 3))
      0: t = ham(32'hFFFF_FFFF);
      1: t = ham({$urandom_range(0, 33554431), 7'b0001011}[31:0]);
      2: begin
        t = kodla(ISLEM_BEQ, 5'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 8);
        t.kelime[14:12] = 3'b010; t.gecersiz = 1'b1; t.islem = ISLEM_NOP;
      end
      default: begin
        t = kodla(ISLEM_ADD, 5'($urandom_range(1, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 0);
        t.kelime[31:25] = 7'b0000001; t.gecersiz = 1'b1; t.islem = ISLEM_NOP;
      end
    endcase
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  // mod: 0 = every field, 1 = bubble (flags only), 2 = illegal (flags + fields)
  typedef struct {
    logic        gecerli, rd_yaz, ongoru, gecersiz, yuk;
    logic [31:0] ps, imm, rs1_deger, rs2_deger;
    logic [5:0]  islem;
    logic [4:0]  rd, rs1, rs2;
    int          mod;
  } beklenen_t;

  beklenen_t exp_q[$];
  beklenen_t model;
  int karsilastirma = 0;
  int hatalar = 0;
  logic [31:0] ps_sayac = 32'h100;

  task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    karsilastirma++;
    if (gercek !== beklenen) begin
      hatalar++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  // Monitor: every clock the registered bundle is compared with the queue head
  initial begin
    beklenen_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        kontrol("gecerli_o", 32'(gecerli_o), 32'(e.gecerli));
        kontrol("rd_yaz_o", 32'(rd_yaz_o), 32'(e.rd_yaz));
        kontrol("ongoru_gecerli_o", 32'(ongoru_gecerli_o), 32'(e.ongoru));
        kontrol("gecersiz_buyruk_o", 32'(gecersiz_buyruk_o), 32'(e.gecersiz));
        if (e.mod != 1) begin
          kontrol("ps_o", ps_o, e.ps);
          kontrol("rd_o", 32'(rd_o), 32'(e.rd));
          kontrol("rs1_o", 32'(rs1_o), 32'(e.rs1));
          kontrol("rs2_o", 32'(rs2_o), 32'(e.rs2));
          kontrol("rs1_deger_o", rs1_deger_o, e.rs1_deger);
          kontrol("rs2_deger_o", rs2_deger_o, e.rs2_deger);
        end
        if (e.mod == 0) begin
          kontrol("islem_o", 32'(islem_o), 32'(e.islem));
          kontrol("imm_o", imm_o, e.imm);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle: drive inputs, check combinational outputs, advance the model
  task automatic adim(input tanim_t t, input logic [31:0] ps, input logic ongoru,
                      input logic dur, input logic bos, input logic rst,
                      output logic stall);
    logic hazard;
    logic [4:0] a1, a2;
    @(negedge clk_i);
    rst_i = rst; bosalt_i = bos; durdur_i = dur; buyruk_i = t.kelime;
    ps_i = ps; ongoru_gecerli_i = ongoru;
    rs1_veri_i = $urandom; rs2_veri_i = $urandom;
    a1 = t.kelime[19:15]; a2 = t.kelime[24:20];
    #1;
    hazard = !rst && !bos && model.gecerli && model.yuk && (model.rd != 5'd0) &&
             (((model.rd == a1) && t.kul1) || ((model.rd == a2) && t.kul2));
    stall = dur || hazard;
    kontrol("durdur_o", 32'(durdur_o), 32'(stall));
    kontrol("rs1_adres_o", 32'(rs1_adres_o), 32'(a1));
    kontrol("rs2_adres_o", 32'(rs2_adres_o), 32'(a2));
    if (rst) begin
      model = '{gecerli: 1'b0, rd_yaz: 1'b0, ongoru: 1'b0, gecersiz: 1'b0, yuk: 1'b0,
                ps: 32'd0, imm: 32'd0, rs1_deger: 32'd0, rs2_deger: 32'd0,
                islem: ISLEM_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, mod: 0};
    end else if (bos || (hazard && !dur)) begin
      model.gecerli = 1'b0; model.rd_yaz = 1'b0; model.ongoru = 1'b0;
      model.gecersiz = 1'b0; model.yuk = 1'b0; model.mod = 1;
    end else if (!dur) begin
      model.gecerli   = (t.kelime != 32'h13);
      model.ps        = ps;
      model.islem     = t.islem;
      model.rd        = t.kelime[11:7];
      model.rd_yaz    = t.yazar && !t.gecersiz && (t.kelime[11:7] != 5'd0);
      model.imm       = t.imm;
      model.rs1       = a1;
      model.rs2       = a2;
      model.rs1_deger = (a1 == 5'd0) ? 32'd0 : rs1_veri_i;
      model.rs2_deger = (a2 == 5'd0) ? 32'd0 : rs2_veri_i;
      model.ongoru    = ongoru;
      model.gecersiz  = t.gecersiz;
      model.yuk       = t.yukleme && !t.gecersiz;
      model.mod       = t.gecersiz ? 2 : ((t.kelime == 32'h13) ? 1 : 0);
    end
    exp_q.push_back(model);
  endtask

  // Issue one instruction, re-presenting it while the stage asks to hold
  task automatic ver(input tanim_t t, input logic ongoru, input logic dur, input logic bos);
    logic s;
    int n;
    n = 0;
    do begin
      adim(t, ps_sayac, ongoru, dur, bos, 1'b0, s);
      n++;
    end while (s && !bos && (n < 4));
    ps_sayac += 4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    tanim_t nop, t;
    logic s;
    logic dur, bos, rst;
    model = '{gecerli: 1'b0, rd_yaz: 1'b0, ongoru: 1'b0, gecersiz: 1'b0, yuk: 1'b0,
              ps: 32'd0, imm: 32'd0, rs1_deger: 32'd0, rs2_deger: 32'd0,
              islem: ISLEM_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, mod: 0};
    nop = kodla(ISLEM_ADDI, 5'd0, 5'd0, 5'd0, 0);

    // reset state
    adim(nop, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    adim(nop, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, s);

    // addi x1,x0,5 at PC 0x100
    ver(kodla(ISLEM_ADDI, 5'd1, 5'd0, 5'd0, 5), 1'b0, 1'b0, 1'b0);
    // lw x2,0(x1) ; add x3,x2,x2 -> one stall, one bubble
    ver(kodla(ISLEM_LW, 5'd2, 5'd1, 5'd0, 0), 1'b0, 1'b0, 1'b0);
    ver(kodla(ISLEM_ADD, 5'd3, 5'd2, 5'd2, 0), 1'b0, 1'b0, 1'b0);
    // lw x0,0(x1) ; add x3,x0,x0 -> no hazard
    ver(kodla(ISLEM_LW, 5'd0, 5'd1, 5'd0, 0), 1'b0, 1'b0, 1'b0);
    ver(kodla(ISLEM_ADD, 5'd3, 5'd0, 5'd0, 0), 1'b0, 1'b0, 1'b0);
    // stall and flush together
    ver(kodla(ISLEM_ADDI, 5'd4, 5'd1, 5'd0, -7), 1'b0, 1'b1, 1'b1);
    // beq x0,x0,-4 predicted taken
    ver(kodla(ISLEM_BEQ, 5'd0, 5'd0, 5'd0, -4), 1'b1, 1'b0, 1'b0);
    // all-ones word is illegal, then a reset pulse clears the flags
    ver(ham(32'hFFFF_FFFF), 1'b0, 1'b0, 1'b0);
    adim(nop, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, s);
    // hazard pending when reset arrives leaves no residue
    ver(kodla(ISLEM_LW, 5'd1, 5'd2, 5'd0, 12), 1'b0, 1'b0, 1'b0);
    adim(kodla(ISLEM_SW, 5'd0, 5'd2, 5'd1, 4), ps_sayac, 1'b0, 1'b1, 1'b0, 1'b1, s);
    ver(kodla(ISLEM_SW, 5'd0, 5'd2, 5'd1, 4), 1'b0, 1'b0, 1'b0);

    // randomized traffic; the bench plays getir and holds while stalled
    t = rastgele_gecerli();
    for (int i = 0; i < 800; i++) begin
      dur = ($urandom_range(0, 6) == 0);
      bos = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      adim(t, ps_sayac, (t.kelime[6:0] == OPK_BRANCH) && ($urandom_range(0, 1) == 1),
           dur, bos, rst, s);
      if (!s || bos || rst) begin
        ps_sayac += 4;
        case ($urandom_range(0, 9))
          0:       t = nop;
          1:       t = rastgele_gecersiz();
          default: t = rastgele_gecerli();
        endcase
      end
    end

    adim(nop, ps_sayac, 1'b0, 1'b0, 1'b0, 1'b0, s);
    @(posedge clk_i);
    @(posedge clk_i);
    #3;
    kontrol("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, hatalar);
    $finish;
  end

endmodule
